alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Issue-side initiator for the ALU lanes. Buffers dispatched instructions and snoops per-ALU result broadcasts to wake up pending source operands.
//  Each cycle it selects up to NUM_ALU ready entries and drives one registered issue packet per lane.
//  alu_number[i] selects ALU i; each lane carries its own optype, sr1, sr2, imm and dr.
// PARAMETERS
//  DEPTH    8   queue entries (power of 2, >=NUM_ALU)
//  NUM_ALU  3   ALU lanes / broadcast ports
//  TAG_W    6   physical register tag width
//  DATA_W   32  operand width
// PORTS
//  clk              in   1              clock; all state changes on rising edge
//  rst              in   1              synchronous reset, active-high
//  flush            in   1              sync clear of all entries (branch/exception recovery)
//  disp_valid       in   1              dispatch request
//  disp_ready       out  1              queue has a free entry (occupancy < DEPTH)
//  disp_optype      in   4              1 ADD,2 ADDI,3 LUI,4 ORI,5 XOR,6 SRAI,7 LB,8 LW,9 SB,10 SW
//  disp_dr          in   TAG_W          destination tag
//  disp_src1_tag    in   TAG_W          source-1 tag
//  disp_src1_rdy    in   1              source-1 value is valid in disp_src1_data
//  disp_src1_data   in   DATA_W         source-1 value
//  disp_src2_tag    in   TAG_W          source-2 tag
//  disp_src2_rdy    in   1              source-2 value is valid in disp_src2_data
//  disp_src2_data   in   DATA_W         source-2 value
//  disp_imm         in   DATA_W         immediate
//  bc_valid         in   NUM_ALU        per-ALU broadcast valid (ALU FU_is_using)
//  bc_tag           in   NUM_ALU*TAG_W  per-ALU broadcast tag (ALU dr_out)
//  bc_data          in   NUM_ALU*DATA_W per-ALU broadcast value (ALU data_out_dr)
//  alu_number       out  NUM_ALU        one-hot-per-lane issue valid; bit i drives ALU i
//  iss_optype       out  NUM_ALU*4      per-lane optype
//  iss_sr1/iss_sr2  out  NUM_ALU*DATA_W per-lane operands
//  iss_imm          out  NUM_ALU*DATA_W per-lane immediate
//  iss_dr           out  NUM_ALU*TAG_W  per-lane destination tag
//  occupancy        out  $clog2(DEPTH)+1 valid entry count
//  err_bad_op       out  1              1-cycle pulse: dispatch with optype 0 or 11..15
// BEHAVIOUR
//  Reset/flush: all entries invalid. alu_number, iss_*, occupancy and err_bad_op are 0 the next cycle; disp_ready=1.
//    rst and flush win over a same-cycle dispatch; an in-flight issue is not cancelled (ALUs are combinational).
//  Dispatch: accepted when disp_valid & disp_ready; written into the lowest-index free entry.
//    A bad optype is not allocated and pulses err_bad_op the next cycle.
//    disp_ready reflects current occupancy only; a slot freed by a same-cycle issue is reusable next cycle.
//  Wakeup: for each valid entry and each lane k, a non-ready src with tag==bc_tag[k] & bc_valid[k] sets rdy and captures bc_data[k].
//    Dispatch snoops the same-cycle broadcast identically, so no wakeup is lost.
//    Tag 0 is never matched: broadcast with tag 0 ignored.
//  Readiness: entry ready when src1 rdy and src2 rdy.
//    ADDI/ORI/SRAI/LB/LW ignore src2; the queue forces src2 rdy at dispatch. LUI forces both rdy.
//  Select: up to NUM_ALU ready entries per cycle, assigned to lanes 0..NUM_ALU-1 in priority order; unused lanes get alu_number[i]=0.
//    Issue outputs are registered: selected in cycle N, visible in N+1, and the entry is freed at the end of N.
//    Unused-lane iss_* are driven 0.
//  Latency: dispatch with both srcs ready in cycle N -> issued (alu_number set) in N+2.
//    Broadcast in N -> dependent visible on a lane in N+2.
//  Simultaneous dispatch + issue + wakeup in one cycle are all legal; occupancy += accepted - issued.
//  Full: disp_valid while disp_ready=0 is ignored (no state change, no error).
// CONFIGURATION
//  IQ_OLDEST_FIRST_EN defined: each entry carries an age stamp (wrapping counter, width $clog2(DEPTH)+1).
//    Select picks the oldest ready entries, oldest to lane 0.
//  IQ_OLDEST_FIRST_EN undefined: priority is lowest entry index first, with no age state.
// STRUCTURE
//  Package ooo_iq_pkg: OP_ADD..OP_SW localparams (1..10); iq_entry_t (valid, optype, dr, src1/2 tag/rdy/data, imm, age);
//    helper function uses_src2(optype).
//  Sub-module iq_select: combinational picker; ready vector (+ ages) in -> NUM_ALU one-hot grant vectors.
//  Top holds the entry array, wakeup CAM, allocator and output registers.
// TESTING
//  1 Dispatch ADD (dr=5, srcs ready, 3 and 4) -> N+2: alu_number=001, iss_sr1=3, iss_sr2=4, iss_dr=5; occupancy back to 0.
//  2 ADD waiting on src1 tag 7; bc_valid[1]=1, bc_tag=7, bc_data=0x10 -> entry issues 2 cycles later with iss_sr1=0x10.
//  3 Dispatch 8 non-ready entries -> disp_ready=0; 9th dispatch ignored; one wakeup -> issue, and disp_ready=1 the cycle after.
//  4 Four ready entries at once -> lanes 0..2 issue (alu_number=111), 4th issues next cycle; oldest-first order when IQ_OLDEST_FIRST_EN.
//  5 Dispatch with src1 tag=9 in the same cycle as bc_tag=9 -> captured, issues at N+2; bc_tag=0 never wakes anything.
//  6 optype=12 -> err_bad_op pulse, occupancy unchanged; flush with 5 entries -> occupancy=0, alu_number=0 next cycle.

Source files
------------

// File: rtl/ooo_iq_pkg.sv
// ooo_iq_pkg: opcodes, the issue-queue entry layout and small helpers shared by the queue and its picker.
package ooo_iq_pkg;
   localparam int IQ_DEPTH  = 8;
   localparam int IQ_TAG_W  = 6;
   localparam int IQ_DATA_W = 32;
   localparam int IQ_AGE_W  = $clog2(IQ_DEPTH) + 1;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADDI = 4'd2;
   localparam logic [3:0] OP_LUI  = 4'd3;
   localparam logic [3:0] OP_ORI  = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRAI = 4'd6;
   localparam logic [3:0] OP_LB   = 4'd7;
   localparam logic [3:0] OP_LW   = 4'd8;
   localparam logic [3:0] OP_SB   = 4'd9;
   localparam logic [3:0] OP_SW   = 4'd10;
   typedef struct packed {
      logic                 valid;
      logic [3:0]           optype;
      logic [IQ_TAG_W-1:0]  dr;
      logic [IQ_TAG_W-1:0]  src1_tag;
      logic                 src1_rdy;
      logic [IQ_DATA_W-1:0] src1_data;
      logic [IQ_TAG_W-1:0]  src2_tag;
      logic                 src2_rdy;
      logic [IQ_DATA_W-1:0] src2_data;
      logic [IQ_DATA_W-1:0] imm;
      logic [IQ_AGE_W-1:0]  age;
   } iq_entry_t;
   function automatic logic uses_src2(input logic [3:0] optype);
      return optype == OP_ADD || optype == OP_XOR || optype == OP_SB || optype == OP_SW;
   endfunction
   // a was stamped before b when b is a short forward distance ahead on the wrapping counter
   function automatic logic age_older(input logic [IQ_AGE_W-1:0] a, input logic [IQ_AGE_W-1:0] b);
      logic [IQ_AGE_W-1:0] d;
      d = b - a;
      return d != '0 && !d[IQ_AGE_W-1];
   endfunction
endpackage

// File: rtl/iq_select.sv
// iq_select: combinational picker granting up to NUM_ALU ready entries, one one-hot vector per lane.
// IQ_OLDEST_FIRST_EN selects oldest-first by age stamp; otherwise lowest index wins.
module iq_select
   import ooo_iq_pkg::*;
#(
   parameter int DEPTH   = IQ_DEPTH,
   parameter int NUM_ALU = 3
)(
   input  logic [DEPTH-1:0]                ready,
`ifdef IQ_OLDEST_FIRST_EN
   input  logic [DEPTH-1:0][IQ_AGE_W-1:0]  ages,
`endif
   output logic [NUM_ALU-1:0][DEPTH-1:0]   grant
);
   localparam logic [DEPTH-1:0] ONE = 1;
   logic [DEPTH-1:0] rem, cand;
   always_comb begin
      rem  = ready;
      cand = '0;
      for (int k = 0; k < NUM_ALU; k++) begin
         cand = rem;
`ifdef IQ_OLDEST_FIRST_EN
         for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
               if (rem[j] && j != i && age_older(ages[j], ages[i])) cand[i] = 1'b0;
`endif
         grant[k] = cand & (~cand + ONE);
         rem      = rem & ~grant[k];
      end
   end
endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers dispatched ALU ops, wakes operands from per-lane broadcasts, issues up to NUM_ALU per cycle.
// Define IQ_OLDEST_FIRST_EN for oldest-first issue; default build issues lowest entry index first.
module alu_issue_queue
   import ooo_iq_pkg::*;
#(
   parameter int DEPTH   = IQ_DEPTH,
   parameter int NUM_ALU = 3,
   parameter int TAG_W   = IQ_TAG_W,
   parameter int DATA_W  = IQ_DATA_W
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        disp_valid,
   output logic                        disp_ready,
   input  logic [3:0]                  disp_optype,
   input  logic [TAG_W-1:0]            disp_dr,
   input  logic [TAG_W-1:0]            disp_src1_tag,
   input  logic                        disp_src1_rdy,
   input  logic [DATA_W-1:0]           disp_src1_data,
   input  logic [TAG_W-1:0]            disp_src2_tag,
   input  logic                        disp_src2_rdy,
   input  logic [DATA_W-1:0]           disp_src2_data,
   input  logic [DATA_W-1:0]           disp_imm,
   input  logic [NUM_ALU-1:0]          bc_valid,
   input  logic [NUM_ALU*TAG_W-1:0]    bc_tag,
   input  logic [NUM_ALU*DATA_W-1:0]   bc_data,
   output logic [NUM_ALU-1:0]          alu_number,
   output logic [NUM_ALU*4-1:0]        iss_optype,
   output logic [NUM_ALU*DATA_W-1:0]   iss_sr1,
   output logic [NUM_ALU*DATA_W-1:0]   iss_sr2,
   output logic [NUM_ALU*DATA_W-1:0]   iss_imm,
   output logic [NUM_ALU*TAG_W-1:0]    iss_dr,
   output logic [$clog2(DEPTH):0]      occupancy,
   output logic                        err_bad_op
);
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam int IDX_W = $clog2(DEPTH);
   iq_entry_t                    q [DEPTH];
   iq_entry_t                    q_nxt [DEPTH];
   iq_entry_t                    new_e;
   logic [DEPTH-1:0]             rdy_vec;
   logic [NUM_ALU-1:0][DEPTH-1:0] grant;
   logic [IDX_W-1:0]             free_idx;
   logic                         bad_op, accept;
   logic [NUM_ALU-1:0]           alu_nxt;
   logic [NUM_ALU*4-1:0]         op_nxt;
   logic [NUM_ALU*DATA_W-1:0]    sr1_nxt, sr2_nxt, imm_nxt;
   logic [NUM_ALU*TAG_W-1:0]     dr_nxt;
`ifdef IQ_OLDEST_FIRST_EN
   logic [IQ_AGE_W-1:0]          age_ctr;
   logic [DEPTH-1:0][IQ_AGE_W-1:0] ages;
`endif
   // tag 0 is the architectural zero register and never produced by an ALU
   function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] tag, input logic rdy, input logic [DATA_W-1:0] data);
      logic [DATA_W:0] r;
      r = {rdy, data};
      for (int k = 0; k < NUM_ALU; k++)
         if (!rdy && bc_valid[k] && tag != '0 && bc_tag[k*TAG_W +: TAG_W] == tag) r = {1'b1, bc_data[k*DATA_W +: DATA_W]};
      return r;
   endfunction
   always_comb begin
      occupancy = '0;
      free_idx  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         occupancy  = occupancy + OCC_W'(q[i].valid);
         free_idx   = q[i].valid ? free_idx : IDX_W'(i);
         rdy_vec[i] = q[i].valid & q[i].src1_rdy & q[i].src2_rdy;
`ifdef IQ_OLDEST_FIRST_EN
         ages[i]    = q[i].age;
`endif
      end
   end
   assign disp_ready = occupancy < OCC_W'(DEPTH);
   assign bad_op     = disp_optype == 4'd0 || disp_optype > OP_SW;
   assign accept     = disp_valid & disp_ready & ~bad_op;
   iq_select #(.DEPTH(DEPTH), .NUM_ALU(NUM_ALU)) u_select (
      .ready (rdy_vec),
`ifdef IQ_OLDEST_FIRST_EN
      .ages  (ages),
`endif
      .grant (grant)
   );
   // wakeup, then free the entries granted this cycle, then allocate into a slot that was already free
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         q_nxt[i] = q[i];
         {q_nxt[i].src1_rdy, q_nxt[i].src1_data} = snoop(q[i].src1_tag, q[i].src1_rdy, q[i].src1_data);
         {q_nxt[i].src2_rdy, q_nxt[i].src2_data} = snoop(q[i].src2_tag, q[i].src2_rdy, q[i].src2_data);
         for (int k = 0; k < NUM_ALU; k++)
            if (grant[k][i]) q_nxt[i].valid = 1'b0;
      end
      new_e          = '0;
      new_e.valid    = 1'b1;
      new_e.optype   = disp_optype;
      new_e.dr       = disp_dr;
      new_e.src1_tag = disp_src1_tag;
      new_e.src2_tag = disp_src2_tag;
      new_e.imm      = disp_imm;
      {new_e.src1_rdy, new_e.src1_data} = snoop(disp_src1_tag, disp_src1_rdy | (disp_optype == OP_LUI), disp_src1_data);
      {new_e.src2_rdy, new_e.src2_data} = snoop(disp_src2_tag, disp_src2_rdy | ~uses_src2(disp_optype), disp_src2_data);
`ifdef IQ_OLDEST_FIRST_EN
      new_e.age      = age_ctr;
`endif
      if (accept) q_nxt[free_idx] = new_e;
   end
   always_comb begin
      alu_nxt = '0;
      op_nxt  = '0;
      sr1_nxt = '0;
      sr2_nxt = '0;
      imm_nxt = '0;
      dr_nxt  = '0;
      for (int k = 0; k < NUM_ALU; k++)
         for (int i = 0; i < DEPTH; i++)
            if (grant[k][i]) begin
               alu_nxt[k]                 = 1'b1;
               op_nxt[k*4 +: 4]           = q[i].optype;
               sr1_nxt[k*DATA_W +: DATA_W] = q[i].src1_data;
               sr2_nxt[k*DATA_W +: DATA_W] = q[i].src2_data;
               imm_nxt[k*DATA_W +: DATA_W] = q[i].imm;
               dr_nxt[k*TAG_W +: TAG_W]   = q[i].dr;
            end
   end
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         alu_number <= '0;
         iss_optype <= '0;
         iss_sr1    <= '0;
         iss_sr2    <= '0;
         iss_imm    <= '0;
         iss_dr     <= '0;
         err_bad_op <= 1'b0;
`ifdef IQ_OLDEST_FIRST_EN
         age_ctr    <= '0;
`endif
      end else begin
         q          <= q_nxt;
         alu_number <= alu_nxt;
         iss_optype <= op_nxt;
         iss_sr1    <= sr1_nxt;
         iss_sr2    <= sr2_nxt;
         iss_imm    <= imm_nxt;
         iss_dr     <= dr_nxt;
         err_bad_op <= disp_valid & disp_ready & bad_op;
`ifdef IQ_OLDEST_FIRST_EN
         age_ctr    <= age_ctr + IQ_AGE_W'(accept);
`endif
      end
   end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench; expected issue packets are queued at stimulus time and popped per issuing lane.
module tb_alu_issue_queue;
   import ooo_iq_pkg::*;
   localparam int N  = 3;
   localparam int TW = 6;
   localparam int DW = 32;
   logic            clk = 1'b0;
   logic            rst, flush, disp_valid, disp_ready;
   logic [3:0]      disp_optype;
   logic [TW-1:0]   disp_dr, disp_src1_tag, disp_src2_tag;
   logic            disp_src1_rdy, disp_src2_rdy;
   logic [DW-1:0]   disp_src1_data, disp_src2_data, disp_imm;
   logic [N-1:0]    bc_valid;
   logic [N*TW-1:0] bc_tag;
   logic [N*DW-1:0] bc_data;
   logic [N-1:0]    alu_number;
   logic [N*4-1:0]  iss_optype;
   logic [N*DW-1:0] iss_sr1, iss_sr2, iss_imm;
   logic [N*TW-1:0] iss_dr;
   logic [3:0]      occupancy;
   logic            err_bad_op;
   int              n_checks = 0;
   int              n_fail = 0;
   bit              mon_en = 1'b0;
   logic [127:0]    sb [$];
   alu_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_optype(disp_optype), .disp_dr(disp_dr), .disp_src1_tag(disp_src1_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src1_data(disp_src1_data), .disp_src2_tag(disp_src2_tag),
      .disp_src2_rdy(disp_src2_rdy), .disp_src2_data(disp_src2_data), .disp_imm(disp_imm),
      .bc_valid(bc_valid), .bc_tag(bc_tag), .bc_data(bc_data), .alu_number(alu_number),
      .iss_optype(iss_optype), .iss_sr1(iss_sr1), .iss_sr2(iss_sr2), .iss_imm(iss_imm),
      .iss_dr(iss_dr), .occupancy(occupancy), .err_bad_op(err_bad_op)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [127:0] pk(input logic [3:0] op, input logic [31:0] sr1, input logic [31:0] sr2, input logic [31:0] imm, input logic [5:0] dr);
      return {22'd0, op, sr1, sr2, imm, dr};
   endfunction
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic idle();
      disp_valid = 1'b0;
      bc_valid   = '0;
      flush      = 1'b0;
   endtask
   task automatic disp(input logic [3:0] op, input logic [5:0] dr, input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic r2, input logic [31:0] d2, input logic [31:0] imm);
      disp_valid = 1'b1;
      disp_optype = op;
      disp_dr = dr;
      disp_src1_tag = t1;
      disp_src1_rdy = r1;
      disp_src1_data = d1;
      disp_src2_tag = t2;
      disp_src2_rdy = r2;
      disp_src2_data = d2;
      disp_imm = imm;
   endtask
   task automatic bc(input int k, input logic [5:0] t, input logic [31:0] d);
      bc_valid[k] = 1'b1;
      bc_tag[k*TW +: TW] = t;
      bc_data[k*DW +: DW] = d;
   endtask
   always @(negedge clk) begin
      if (mon_en) begin
         for (int k = 0; k < N; k++) begin
            logic [127:0] lane;
            lane = {22'd0, iss_optype[k*4 +: 4], iss_sr1[k*DW +: DW], iss_sr2[k*DW +: DW], iss_imm[k*DW +: DW], iss_dr[k*TW +: TW]};
            if (alu_number[k]) begin
               check("issue_expected", 128'(sb.size() != 0), 128'd1);
               if (sb.size() != 0) check($sformatf("lane%0d_pkt", k), lane, sb.pop_front());
            end else check($sformatf("lane%0d_idle_zero", k), lane, 128'd0);
         end
      end
   end
   initial begin
      rst = 1'b1;
      bc_tag = '0;
      bc_data = '0;
      idle();
      disp(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
      disp_valid = 1'b0;
      step(2);
      rst = 1'b0;
      mon_en = 1'b1;
      check("rst_occ", 128'(occupancy), 0);
      check("rst_ready", 128'(disp_ready), 1);
      check("rst_alu", 128'(alu_number), 0);
      check("rst_err", 128'(err_bad_op), 0);
      // ready ADD issues two cycles after dispatch
      disp(OP_ADD, 5, 1, 1, 3, 2, 1, 4, 32'h11);
      sb.push_back(pk(OP_ADD, 3, 4, 32'h11, 5));
      step();
      idle();
      check("t1_occ1", 128'(occupancy), 1);
      step();
      check("t1_alu", 128'(alu_number), 3'b001);
      check("t1_occ0", 128'(occupancy), 0);
      // src1 waits on tag 7, woken by lane 1
      disp(OP_ADD, 6, 7, 0, 0, 1, 1, 2, 0);
      step();
      idle();
      step(2);
      check("t2_wait", 128'(alu_number), 0);
      bc(1, 7, 32'h10);
      sb.push_back(pk(OP_ADD, 32'h10, 2, 0, 6));
      step();
      idle();
      step();
      check("t2_alu", 128'(alu_number), 3'b001);
      // fill the queue, overflow dispatch ignored, one wakeup frees a slot
      for (int i = 0; i < 8; i++) begin
         disp(OP_ADD, 6'(i + 1), 6'(20 + i), 0, 0, 1, 1, 32'(i), 32'(i));
         step();
      end
      idle();
      check("t3_full_ready", 128'(disp_ready), 0);
      check("t3_full_occ", 128'(occupancy), 8);
      disp(OP_ADD, 63, 40, 0, 0, 1, 1, 0, 0);
      step();
      idle();
      check("t3_ovf_occ", 128'(occupancy), 8);
      check("t3_ovf_err", 128'(err_bad_op), 0);
      bc(0, 23, 32'h123);
      sb.push_back(pk(OP_ADD, 32'h123, 3, 3, 4));
      step();
      idle();
      check("t3_still_full", 128'(disp_ready), 0);
      step();
      check("t3_alu", 128'(alu_number), 3'b001);
      check("t3_ready_again", 128'(disp_ready), 1);
      check("t3_occ7", 128'(occupancy), 7);
      for (int g = 0; g < 3; g++) begin
         int base;
         int cnt;
         base = (g == 0) ? 0 : (g == 1) ? 4 : 7;
         cnt  = (g == 2) ? 1 : 3;
         for (int j = 0; j < cnt; j++) begin
            bc(j, 6'(20 + base + j), 32'h100 + 32'(base + j));
            sb.push_back(pk(OP_ADD, 32'h100 + 32'(base + j), 32'(base + j), 32'(base + j), 6'(base + j + 1)));
         end
         step();
         idle();
         step();
         check($sformatf("t3_drain%0d_alu", g), 128'(alu_number), (g == 2) ? 128'd1 : 128'd7);
      end
      check("t3_occ0", 128'(occupancy), 0);
      // four entries woken together: three lanes now, the fourth next cycle
      for (int i = 0; i < 4; i++) begin
         disp(OP_XOR, 6'(10 + i), 11, 0, 0, 1, 1, 32'h40 + 32'(i), 0);
         step();
      end
      idle();
      bc(2, 11, 32'h77);
      for (int i = 0; i < 4; i++) sb.push_back(pk(OP_XOR, 32'h77, 32'h40 + 32'(i), 0, 6'(10 + i)));
      step();
      idle();
      step();
      check("t4_alu3", 128'(alu_number), 3'b111);
      step();
      check("t4_alu1", 128'(alu_number), 3'b001);
      check("t4_occ0", 128'(occupancy), 0);
      // dispatch snoops a same-cycle broadcast
      disp(OP_ADD, 12, 9, 0, 0, 1, 1, 5, 0);
      bc(0, 9, 32'h99);
      sb.push_back(pk(OP_ADD, 32'h99, 5, 0, 12));
      step();
      idle();
      step();
      check("t5_snoop_alu", 128'(alu_number), 3'b001);
      disp(OP_ADDI, 13, 1, 1, 7, 50, 0, 32'hdead, 32'h20);
      sb.push_back(pk(OP_ADDI, 7, 32'hdead, 32'h20, 13));
      step();
      idle();
      step();
      check("t5_addi_alu", 128'(alu_number), 3'b001);
      disp(OP_LUI, 14, 51, 0, 32'ha, 52, 0, 32'hb, 32'h5000);
      sb.push_back(pk(OP_LUI, 32'ha, 32'hb, 32'h5000, 14));
      step();
      idle();
      step();
      check("t5_lui_alu", 128'(alu_number), 3'b001);
      disp(OP_ADD, 15, 0, 0, 0, 1, 1, 1, 0);
      bc(0, 0, 32'h55);
      step();
      idle();
      bc(1, 0, 32'h66);
      step();
      idle();
      step();
      check("t5_tag0_alu", 128'(alu_number), 0);
      check("t5_tag0_occ", 128'(occupancy), 1);
      // bad optypes pulse the error and allocate nothing
      disp(4'd12, 16, 1, 1, 0, 1, 1, 0, 0);
      step();
      idle();
      check("t6_err12", 128'(err_bad_op), 1);
      check("t6_err12_occ", 128'(occupancy), 1);
      step();
      check("t6_err_pulse", 128'(err_bad_op), 0);
      disp(4'd0, 16, 1, 1, 0, 1, 1, 0, 0);
      step();
      idle();
      check("t6_err0", 128'(err_bad_op), 1);
      check("t6_err0_occ", 128'(occupancy), 1);
      for (int i = 0; i < 4; i++) begin
         disp(OP_SW, 6'(20 + i), 60, 0, 0, 1, 1, 0, 0);
         step();
      end
      idle();
      check("t6_occ5", 128'(occupancy), 5);
      disp(OP_ADD, 30, 1, 1, 1, 1, 1, 1, 0);
      flush = 1'b1;
      step();
      idle();
      check("t6_flush_occ", 128'(occupancy), 0);
      check("t6_flush_alu", 128'(alu_number), 0);
      check("t6_flush_ready", 128'(disp_ready), 1);
      step();
      check("t6_flush_no_issue", 128'(alu_number), 0);
      step();
      check("sb_empty", 128'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
